arb_request_agent: RTL

- Requester side of the dynamic-priority round-robin arbiter interface: drives `req` and per-client `prt`, and consumes `grant`/`valid`.
- Holds a pending-job counter per client and raises `req` while jobs remain.
- Ages each waiting client's priority on every arbiter tick, and applies a post-grant holdoff.
- Runs on the same `clk`/`clk_en` tick as the arbiter it feeds, so both ends advance in lockstep.

---
 rtl/arb_request_agent_if.sv | 13 +
 rtl/arb_request_agent.sv | 110 +++++++++++
 2 files changed

// File: rtl/arb_request_agent_if.sv
// Requester/arbiter handshake bundle: requests and priorities out, grant back.
interface arb_request_agent_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned LN = $clog2(N)
);
    logic [N-1:0]         req;
    logic [N-1:0][LN-1:0] prt;
    logic [LN-1:0]        grant;
    logic                 valid;

    modport master (output req, prt, input grant, valid);
    modport slave  (input req, prt, output grant, valid);
endinterface

// File: rtl/arb_request_agent.sv
// Requester agent for a dynamic-priority round-robin arbiter: per-client job
// counters, request generation, priority aging and post-grant holdoff.
module arb_request_agent #(
    parameter int unsigned N    = 4,
    parameter int unsigned LN   = $clog2(N),
    parameter int unsigned CW   = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic [N-1:0]           job_push,
    arb_request_agent_if.master    bus,
    output logic [N-1:0]           served,
    output logic                   spurious,
    output logic [N-1:0]           overflow
);

    localparam int unsigned HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [CW-1:0] PendMax  = '1;
    localparam logic [LN-1:0] PrtMax   = LN'(N - 1);
    localparam logic [HW-1:0] HoldInit = HW'(HOLD);

    logic [N-1:0][CW-1:0] pend_q, pend_d;
    logic [N-1:0][HW-1:0] hold_q, hold_d;
    logic [N-1:0][LN-1:0] prt_q, prt_d;
    logic [N-1:0]         req_q, req_d;
    logic [N-1:0]         served_q, served_d;
    logic [N-1:0]         overflow_q, overflow_d;
    logic                 spurious_q, spurious_d;

    logic                 grant_in_range;
    logic                 accept;
    logic [N-1:0]         accept_vec;

    always_comb begin
        grant_in_range = ({1'b0, bus.grant} < (LN + 1)'(N));
        accept         = clk_en && bus.valid && grant_in_range && req_q[bus.grant];
        accept_vec     = '0;
        if (accept) begin
            accept_vec[bus.grant] = 1'b1;
        end
        spurious_d = clk_en && bus.valid && !accept;
        served_d   = accept_vec;

        pend_d     = pend_q;
        overflow_d = overflow_q;
        hold_d     = hold_q;
        prt_d      = prt_q;
        req_d      = req_q;

        for (int i = 0; i < int'(N); i++) begin
            // Job counter runs every clk so pushes between ticks are never lost.
            if (job_push[i] && !accept_vec[i]) begin
                if (pend_q[i] == PendMax) begin
                    overflow_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + CW'(1);
                end
            end else if (!job_push[i] && accept_vec[i]) begin
                pend_d[i] = pend_q[i] - CW'(1);
            end

            if (clk_en) begin
                if (accept_vec[i]) begin
                    hold_d[i] = HoldInit;
                end else if (hold_q[i] != '0) begin
                    hold_d[i] = hold_q[i] - HW'(1);
                end

                if (accept_vec[i]) begin
                    prt_d[i] = '0;
                end else if (req_q[i]) begin
                    prt_d[i] = (prt_q[i] == PrtMax) ? prt_q[i] : prt_q[i] + LN'(1);
                end else begin
                    prt_d[i] = '0;
                end

                req_d[i] = (pend_d[i] != '0) && (hold_d[i] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            hold_q     <= '0;
            prt_q      <= '0;
            req_q      <= '0;
            served_q   <= '0;
            overflow_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            prt_q      <= prt_d;
            req_q      <= req_d;
            served_q   <= served_d;
            overflow_q <= overflow_d;
            spurious_q <= spurious_d;
        end
    end

    assign bus.req  = req_q;
    assign bus.prt  = prt_q;
    assign served   = served_q;
    assign spurious = spurious_q;
    assign overflow = overflow_q;

endmodule
